// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus between the PC sequencer and the PC register / instruction memory.
// FETCH_ALIGN_CHK_EN adds the excF_o fetch-exception code.
interface fetch_sequencer_if #(
   parameter int WORD = 32
);
   logic [WORD-1:0] pc_i;
   logic            stallD_i;
   logic            br_taken_i;
   logic [WORD-1:0] br_target_i;
   logic            exc_req_i;
   logic            eret_i;
   logic [WORD-1:0] epc_i;
   logic            imem_req_o;
   logic            imem_ready_i;
   logic [WORD-1:0] npc_o;
   logic            installF_o;
   logic            flushD_o;
`ifdef FETCH_ALIGN_CHK_EN
   logic [8:0]      excF_o;
`endif

   modport master (
      input  pc_i, stallD_i, br_taken_i, br_target_i, exc_req_i, eret_i, epc_i, imem_ready_i,
      output imem_req_o, npc_o, installF_o, flushD_o
`ifdef FETCH_ALIGN_CHK_EN
      , output excF_o
`endif
   );

   modport slave (
      output pc_i, stallD_i, br_taken_i, br_target_i, exc_req_i, eret_i, epc_i, imem_ready_i,
      input  imem_req_o, npc_o, installF_o, flushD_o
`ifdef FETCH_ALIGN_CHK_EN
      , input excF_o
`endif
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: redirect arbitration, wait-state/hazard hold, one-entry pending redirect.
// Optional misaligned-fetch detection is enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_sequencer #(
   parameter int              WORD       = 32,
   parameter logic [WORD-1:0] PCBASE     = 32'h00003000,
   parameter logic [WORD-1:0] EXC_VECTOR = 32'h00004180
) (
   input logic               clk,
   input logic               rst,
   fetch_sequencer_if.master bus
);
   localparam logic [WORD-1:0] PC_STEP = WORD'(3'd4);

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_WAIT = 2'b10
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic            pend_valid_r;
   logic [WORD-1:0] pend_target_r;
   logic            pend_is_exc_r;
   logic            pend_valid_s;
   logic [WORD-1:0] pend_target_s;
   logic            pend_is_exc_s;

   logic            in_run_s;
   logic            misalign_s;
   logic            fetch_done_s;
   logic            adv_s;
   logic            imem_req_s;
   logic            live_s;
   logic [WORD-1:0] live_target_s;
   logic            redirect_s;
   logic [WORD-1:0] redirect_target_s;

   // Live redirect arbitration: exception, then ERET, then branch/jump.
   always_comb begin
      live_s        = bus.exc_req_i | bus.eret_i | bus.br_taken_i;
      live_target_s = bus.br_target_i;
      if (bus.exc_req_i) begin
         live_target_s = EXC_VECTOR;
      end else if (bus.eret_i) begin
         live_target_s = bus.epc_i;
      end else begin
         live_target_s = bus.br_target_i;
      end
   end

   // Advance decision; the pending target only wins when no live source is present.
   always_comb begin
      in_run_s = (state_r == ST_RUN) || (state_r == ST_WAIT);
`ifdef FETCH_ALIGN_CHK_EN
      misalign_s   = in_run_s && (bus.pc_i[1:0] != 2'b00);
      imem_req_s   = in_run_s & ~misalign_s;
      fetch_done_s = bus.imem_ready_i | misalign_s;
      if (misalign_s) begin
         adv_s = bus.exc_req_i;
      end else begin
         adv_s = in_run_s & fetch_done_s & (~bus.stallD_i | bus.exc_req_i | bus.eret_i);
      end
`else
      misalign_s   = 1'b0;
      imem_req_s   = in_run_s;
      fetch_done_s = bus.imem_ready_i;
      adv_s        = in_run_s & fetch_done_s & (~bus.stallD_i | bus.exc_req_i | bus.eret_i);
`endif
      redirect_s        = live_s | pend_valid_r;
      redirect_target_s = live_s ? live_target_s : pend_target_r;
   end

   // Output drive toward the PC register and the decode stage.
   always_comb begin
      bus.imem_req_o = imem_req_s;
      bus.installF_o = ~adv_s;
      bus.flushD_o   = adv_s & redirect_s;
      if (adv_s) begin
         bus.npc_o = redirect_s ? redirect_target_s : (bus.pc_i + PC_STEP);
      end else begin
         bus.npc_o = bus.pc_i;
      end
`ifdef FETCH_ALIGN_CHK_EN
      bus.excF_o = misalign_s ? 9'h002 : 9'h000;
`endif
   end

   // Next-state for the fetch FSM.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_BOOT: state_s = ST_RUN;
         ST_RUN: begin
            if (imem_req_s && !bus.imem_ready_i) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_WAIT: begin
            if (bus.imem_ready_i) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_WAIT;
            end
         end
         default: state_s = ST_BOOT;
      endcase
   end

   // Pending buffer: a parked exception is only displaced by another exception.
   always_comb begin
      pend_valid_s  = pend_valid_r;
      pend_target_s = pend_target_r;
      pend_is_exc_s = pend_is_exc_r;
      if (adv_s) begin
         pend_valid_s  = 1'b0;
         pend_is_exc_s = 1'b0;
      end else if (live_s && (!pend_valid_r || bus.exc_req_i || !pend_is_exc_r)) begin
         pend_valid_s  = 1'b1;
         pend_target_s = live_target_s;
         pend_is_exc_s = bus.exc_req_i;
      end else begin
         pend_valid_s  = pend_valid_r;
      end
   end

   // State registers; reset abandons any outstanding fetch and parked redirect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_BOOT;
         pend_valid_r  <= 1'b0;
         pend_target_r <= PCBASE;
         pend_is_exc_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         pend_valid_r  <= pend_valid_s;
         pend_target_r <= pend_target_s;
         pend_is_exc_r <= pend_is_exc_s;
      end
   end
endmodule
